// File: rtl/ibuff_if.sv
// Fetch-to-decode bundle for the instruction buffer: fetch line input, resteer/stall
// controls, and the head-of-buffer outputs that feed decode stage 1.
interface ibuff_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8
);
  logic                       fetch_valid;
  logic [2*XLEN-1:0]          fetch_line;
  logic [XLEN-1:0]            fetch_pc;
  logic [1:0]                 fetch_mask;
  logic                       fetch_exception;
  logic                       flush;
  logic                       d1_stall;
  logic                       ibuff_ready;
  logic                       IBuff_valid;
  logic [XLEN-1:0]            IBuff_out;
  logic [XLEN-1:0]            IBuff_pc;
  logic                       IBuff_exception;
  logic [$clog2(DEPTH):0]     count;

  modport master (
    output fetch_valid, fetch_line, fetch_pc, fetch_mask, fetch_exception, flush, d1_stall,
    input  ibuff_ready, IBuff_valid, IBuff_out, IBuff_pc, IBuff_exception, count
  );

  modport slave (
    input  fetch_valid, fetch_line, fetch_pc, fetch_mask, fetch_exception, flush, d1_stall,
    output ibuff_ready, IBuff_valid, IBuff_out, IBuff_pc, IBuff_exception, count
  );
endinterface

// File: rtl/ibuff.sv
// Instruction buffer: circular FIFO taking up to two fetched words per cycle and
// delivering one per cycle in program order to decode; a flush discards everything.
module ibuff #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8
) (
  input  logic  clk,
  input  logic  rst,
  ibuff_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  function automatic logic [1:0] popcount2(input logic [1:0] m);
    popcount2 = {1'b0, m[0]} + {1'b0, m[1]};
  endfunction

  logic [XLEN-1:0] instr_mem_r [DEPTH];
  logic [XLEN-1:0] pc_mem_r    [DEPTH];
  logic [DEPTH-1:0] exc_mem_r;
  logic [PW-1:0]   head_r;
  logic [PW-1:0]   tail_r;
  logic [CW-1:0]   count_r;

  logic            ready_s;
  logic            push_s;
  logic            pop_s;
  logic            dual_s;
  logic [1:0]      push_n_s;
  logic [PW-1:0]   tail_plus1_s;
  logic [XLEN-1:0] first_instr_s;
  logic [XLEN-1:0] first_pc_s;
  logic [XLEN-1:0] slot1_pc_s;
  logic [CW-1:0]   free_s;

  // Free-space, push/pop qualification and first-slot selection.
  always_comb begin
    free_s        = CW'(DEPTH) - count_r;
    ready_s       = (free_s >= CW'(2));
    push_s        = bus.fetch_valid && ready_s && (bus.fetch_mask != 2'b00);
    pop_s         = (count_r != CW'(0)) && !bus.d1_stall;
    dual_s        = (bus.fetch_mask == 2'b11);
    tail_plus1_s  = tail_r + PW'(1);
    slot1_pc_s    = bus.fetch_pc + XLEN'(4);
    if (push_s) begin
      push_n_s = popcount2(bus.fetch_mask);
    end else begin
      push_n_s = 2'b00;
    end
    // A lone slot1 lands at tail, so the first write picks slot1 whenever slot0 is absent.
    if (bus.fetch_mask[0]) begin
      first_instr_s = bus.fetch_line[XLEN-1:0];
      first_pc_s    = bus.fetch_pc;
    end else begin
      first_instr_s = bus.fetch_line[2*XLEN-1:XLEN];
      first_pc_s    = slot1_pc_s;
    end
  end

  // Entry storage; contents persist across reset and flush, only pointers are cleared.
  always_ff @(posedge clk) begin
    if (!rst && !bus.flush && push_s) begin
      instr_mem_r[tail_r] <= first_instr_s;
      pc_mem_r[tail_r]    <= first_pc_s;
      exc_mem_r[tail_r]   <= bus.fetch_exception;
      if (dual_s) begin
        instr_mem_r[tail_plus1_s] <= bus.fetch_line[2*XLEN-1:XLEN];
        pc_mem_r[tail_plus1_s]    <= slot1_pc_s;
        exc_mem_r[tail_plus1_s]   <= bus.fetch_exception;
      end
    end
  end

  // Pointer and occupancy update: reset over flush over push/pop.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      head_r  <= PW'(0);
      tail_r  <= PW'(0);
      count_r <= CW'(0);
    end else begin
      if (push_s) begin
        tail_r <= tail_r + PW'(push_n_s);
      end
      if (pop_s) begin
        head_r <= head_r + PW'(1);
      end
      count_r <= count_r + CW'(push_n_s) - CW'(pop_s);
    end
  end

  // Head presentation reads the oldest entry directly, zeroed when empty.
  always_comb begin
    bus.ibuff_ready = ready_s;
    bus.count       = count_r;
    if (count_r != CW'(0)) begin
      bus.IBuff_valid     = 1'b1;
      bus.IBuff_out       = instr_mem_r[head_r];
      bus.IBuff_pc        = pc_mem_r[head_r];
      bus.IBuff_exception = exc_mem_r[head_r];
    end else begin
      bus.IBuff_valid     = 1'b0;
      bus.IBuff_out       = XLEN'(0);
      bus.IBuff_pc        = XLEN'(0);
      bus.IBuff_exception = 1'b0;
    end
  end
endmodule

// File: tb/tb_ibuff.sv
// Directed self-checking bench for ibuff: one task per scenario, hand-computed expectations.
module tb_ibuff;
  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   violations;

  ibuff_if #(.XLEN(32), .DEPTH(8)) bus ();

  ibuff #(.XLEN(32), .DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fetch presenting a line while the buffer is not ready is a protocol violation.
  always @(posedge clk) begin
    if (!rst && bus.fetch_valid && !bus.ibuff_ready) violations++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] w0, input logic [31:0] w1,
                       input logic [31:0] pc, input logic [1:0] m, input logic e);
    bus.fetch_valid     = v;
    bus.fetch_line      = {w1, w0};
    bus.fetch_pc        = pc;
    bus.fetch_mask      = m;
    bus.fetch_exception = e;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (bus.count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    checks++; if (bus.IBuff_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.IBuff_valid); end
    checks++; if (bus.IBuff_out !== 32'h0) begin failures++; $display("FAIL reset_out got=%h exp=0", bus.IBuff_out); end
    checks++; if (bus.IBuff_pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", bus.IBuff_pc); end
    checks++; if (bus.IBuff_exception !== 1'b0) begin failures++; $display("FAIL reset_exc got=%b exp=0", bus.IBuff_exception); end
    checks++; if (bus.ibuff_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.ibuff_ready); end
  endtask

  task automatic test_basic();
    bus.d1_stall = 1'b0;
    drive(1'b1, 32'h00100093, 32'h00200113, 32'h1000, 2'b11, 1'b0);
    tick();
    idle();
    checks++; if (bus.IBuff_valid !== 1'b1 || bus.IBuff_out !== 32'h00100093 || bus.IBuff_pc !== 32'h1000)
      begin failures++; $display("FAIL basic_slot0 got=%b/%h/%h exp=1/00100093/00001000", bus.IBuff_valid, bus.IBuff_out, bus.IBuff_pc); end
    checks++; if (bus.count !== 4'd2) begin failures++; $display("FAIL basic_count got=%0d exp=2", bus.count); end
    tick();
    checks++; if (bus.IBuff_out !== 32'h00200113 || bus.IBuff_pc !== 32'h1004)
      begin failures++; $display("FAIL basic_slot1 got=%h/%h exp=00200113/00001004", bus.IBuff_out, bus.IBuff_pc); end
    tick();
    checks++; if (bus.IBuff_valid !== 1'b0 || bus.count !== 4'd0)
      begin failures++; $display("FAIL basic_empty got=%b/%0d exp=0/0", bus.IBuff_valid, bus.count); end
  endtask

  task automatic test_mask10();
    bus.d1_stall = 1'b1;
    drive(1'b1, 32'hDEADBEEF, 32'hA5A5A5A5, 32'h2000, 2'b10, 1'b0);
    tick();
    idle();
    checks++; if (bus.count !== 4'd1) begin failures++; $display("FAIL mask10_count got=%0d exp=1", bus.count); end
    checks++; if (bus.IBuff_pc !== 32'h2004 || bus.IBuff_out !== 32'hA5A5A5A5)
      begin failures++; $display("FAIL mask10_head got=%h/%h exp=00002004/a5a5a5a5", bus.IBuff_pc, bus.IBuff_out); end
    bus.d1_stall = 1'b0;
    tick();
    checks++; if (bus.count !== 4'd0) begin failures++; $display("FAIL mask10_drain got=%0d exp=0", bus.count); end
  endtask

  task automatic test_full_wrap();
    int v0;
    bus.d1_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h10000000 + 32'(2*i), 32'h10000000 + 32'(2*i+1), 32'h4000 + 32'(8*i), 2'b11, 1'b0);
      tick();
      checks++; if (bus.count !== 4'(2*i+2)) begin failures++; $display("FAIL full_count_%0d got=%0d exp=%0d", i, bus.count, 2*i+2); end
      checks++; if (bus.ibuff_ready !== (i < 3)) begin failures++; $display("FAIL full_ready_%0d got=%b exp=%b", i, bus.ibuff_ready, (i < 3)); end
      checks++; if (bus.IBuff_pc !== 32'h4000) begin failures++; $display("FAIL full_head_hold_%0d got=%h exp=00004000", i, bus.IBuff_pc); end
    end
    v0 = violations;
    drive(1'b1, 32'hBAD0BAD0, 32'hBAD1BAD1, 32'h9000, 2'b11, 1'b0);
    tick();
    idle();
    checks++; if (bus.count !== 4'd8 || bus.IBuff_pc !== 32'h4000)
      begin failures++; $display("FAIL full_ignore got=%0d/%h exp=8/00004000", bus.count, bus.IBuff_pc); end
    checks++; if (violations !== v0 + 1) begin failures++; $display("FAIL full_violation_seen got=%0d exp=%0d", violations, v0 + 1); end
    bus.d1_stall = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++; if (bus.IBuff_out !== 32'h10000000 + 32'(k) || bus.IBuff_pc !== 32'h4000 + 32'(4*k))
        begin failures++; $display("FAIL drain_%0d got=%h/%h exp=%h/%h", k, bus.IBuff_out, bus.IBuff_pc, 32'h10000000 + 32'(k), 32'h4000 + 32'(4*k)); end
      tick();
      checks++; if (bus.count !== 4'(7-k) || bus.ibuff_ready !== (k >= 1))
        begin failures++; $display("FAIL drain_occ_%0d got=%0d/%b exp=%0d/%b", k, bus.count, bus.ibuff_ready, 7-k, (k >= 1)); end
    end
    checks++; if (bus.IBuff_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got=%b exp=0", bus.IBuff_valid); end
  endtask

  task automatic test_flush();
    bus.d1_stall = 1'b1;
    drive(1'b1, 32'h51, 32'h52, 32'h5000, 2'b11, 1'b0); tick();
    drive(1'b1, 32'h53, 32'h54, 32'h5008, 2'b11, 1'b0); tick();
    drive(1'b1, 32'h55, 32'h56, 32'h5010, 2'b01, 1'b0); tick();
    checks++; if (bus.count !== 4'd5) begin failures++; $display("FAIL flush_fill got=%0d exp=5", bus.count); end
    bus.flush = 1'b1;
    bus.d1_stall = 1'b0;
    drive(1'b1, 32'hF0F0F0F0, 32'hF1F1F1F1, 32'h8000, 2'b11, 1'b0);
    tick();
    bus.flush = 1'b0;
    checks++; if (bus.count !== 4'd0 || bus.IBuff_valid !== 1'b0 || bus.ibuff_ready !== 1'b1)
      begin failures++; $display("FAIL flush_empty got=%0d/%b/%b exp=0/0/1", bus.count, bus.IBuff_valid, bus.ibuff_ready); end
    bus.d1_stall = 1'b1;
    drive(1'b1, 32'h66, 32'h0, 32'h6000, 2'b01, 1'b0);
    tick();
    idle();
    checks++; if (bus.count !== 4'd1 || bus.IBuff_pc !== 32'h6000 || bus.IBuff_out !== 32'h66)
      begin failures++; $display("FAIL flush_refill got=%0d/%h/%h exp=1/00006000/00000066", bus.count, bus.IBuff_pc, bus.IBuff_out); end
    bus.d1_stall = 1'b0;
    tick();
  endtask

  task automatic test_exception();
    bus.d1_stall = 1'b1;
    drive(1'b1, 32'hE0, 32'hE1, 32'h3000, 2'b11, 1'b1); tick();
    drive(1'b1, 32'hE2, 32'h0, 32'h3008, 2'b01, 1'b0); tick();
    idle();
    bus.d1_stall = 1'b0;
    checks++; if (bus.IBuff_exception !== 1'b1 || bus.IBuff_pc !== 32'h3000 || bus.IBuff_out !== 32'hE0)
      begin failures++; $display("FAIL exc_0 got=%b/%h/%h exp=1/00003000/000000e0", bus.IBuff_exception, bus.IBuff_pc, bus.IBuff_out); end
    tick();
    checks++; if (bus.IBuff_exception !== 1'b1 || bus.IBuff_pc !== 32'h3004)
      begin failures++; $display("FAIL exc_1 got=%b/%h exp=1/00003004", bus.IBuff_exception, bus.IBuff_pc); end
    tick();
    checks++; if (bus.IBuff_exception !== 1'b0 || bus.IBuff_pc !== 32'h3008)
      begin failures++; $display("FAIL exc_normal got=%b/%h exp=0/00003008", bus.IBuff_exception, bus.IBuff_pc); end
    tick();
    checks++; if (bus.IBuff_valid !== 1'b0) begin failures++; $display("FAIL exc_empty got=%b exp=0", bus.IBuff_valid); end
  endtask

  task automatic test_stream_rst();
    bus.d1_stall = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'h70 + 32'(i), 32'h0, 32'h7000 + 32'(4*i), 2'b01, 1'b0);
      tick();
      checks++; if (bus.count !== 4'd1 || bus.ibuff_ready !== 1'b1 || bus.IBuff_pc !== 32'h7000 + 32'(4*i))
        begin failures++; $display("FAIL stream_%0d got=%0d/%b/%h exp=1/1/%h", i, bus.count, bus.ibuff_ready, bus.IBuff_pc, 32'h7000 + 32'(4*i)); end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    checks++; if (bus.count !== 4'd0 || bus.IBuff_valid !== 1'b0 || bus.IBuff_out !== 32'h0 ||
                  bus.IBuff_pc !== 32'h0 || bus.IBuff_exception !== 1'b0 || bus.ibuff_ready !== 1'b1)
      begin failures++; $display("FAIL stream_rst got=%0d/%b/%h/%h/%b/%b exp=0/0/0/0/0/1", bus.count, bus.IBuff_valid,
                                  bus.IBuff_out, bus.IBuff_pc, bus.IBuff_exception, bus.ibuff_ready); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    violations = 0;
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.d1_stall = 1'b0;
    idle();
    test_reset();
    test_basic();
    test_mask10();
    test_full_wrap();
    test_flush();
    test_exception();
    test_stream_rst();
    $display("note: fetch protocol violations flagged=%0d", violations);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
